// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank sequencer: run modes, FSM states, JK actions.
package jk_pkg;

    // Run mode encodings as presented on mode_i.
    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_JOHNSON = 2'b10;
    localparam logic [1:0] MODE_CPL     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // JK excitation pairs, packed as {j, k}.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset; qb is derived from q.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o,
    output logic qb_o
);

    logic q_q;
    logic q_d;

    // Apply the JK rule: hold, clear, set or toggle.
    always_comb begin
        q_d = q_q;
        unique case ({j_i, k_i})
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // Cell storage, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o  = q_q;
    assign qb_o = ~q_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequencer for a bank of JK cells: drives J/K so the bank counts up/down, runs a
// Johnson ring or complements for a programmed number of steps, or loads in parallel.
module jk_seq_ctrl
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qb_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             tc_o
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] q, qb;
    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] step_j, step_k;
    logic [WIDTH-1:0] up_t, dn_t;

    // The JK register bank.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .j_i   (j[gi]),
            .k_i   (k[gi]),
            .q_o   (q[gi]),
            .qb_o  (qb[gi])
        );
    end

    // Prefix ANDs of lower bits: bit i toggles when everything below is all-ones (up)
    // or all-zeros (down). Bit 0 sees an empty range and always toggles.
    always_comb begin
        logic up_c;
        logic dn_c;
        up_t = '0;
        dn_t = '0;
        up_c = 1'b1;
        dn_c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = up_c;
            dn_t[i] = dn_c;
            up_c    = up_c & q[i];
            dn_c    = dn_c & qb[i];
        end
    end

    // Per-mode step excitation, using the latched mode.
    always_comb begin
        step_j = '0;
        step_k = '0;
        unique case (mode_q)
            MODE_UP: begin
                step_j = up_t;
                step_k = up_t;
            end
            MODE_DOWN: begin
                step_j = dn_t;
                step_k = dn_t;
            end
            MODE_JOHNSON: begin
                // Shift left, feeding the inverted MSB into bit 0.
                step_j = {q[WIDTH-2:0], qb[WIDTH-1]};
                step_k = {qb[WIDTH-2:0], q[WIDTH-1]};
            end
            MODE_CPL: begin
                step_j = '1;
                step_k = '1;
            end
            default: begin
                step_j = '0;
                step_k = '0;
            end
        endcase
    end

    // Next-state, latching and bank excitation.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        j       = '0;
        k       = '0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Start takes priority over load; the bank holds on this edge.
                    mode_d = mode_i;
                    rem_d  = len_i;
                    state_d = (len_i == '0) ? DONE : RUN;
                end else if (load_i) begin
                    j = load_val_i;
                    k = ~load_val_i;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                j      = step_j;
                k      = step_k;
                rem_d  = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers, aborted asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= MODE_UP;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

    // Terminal count for the latched mode, valid in every state.
    always_comb begin
        tc_o = 1'b0;
        unique case (mode_q)
            MODE_UP:      tc_o = (q == '1);
            MODE_DOWN:    tc_o = (q == '0);
            MODE_JOHNSON: tc_o = (q == {1'b1, {(WIDTH - 1){1'b0}}});
            MODE_CPL:     tc_o = 1'b0;
            default:      tc_o = 1'b0;
        endcase
    end

    assign q_o  = q;
    assign qb_o = qb;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Self-checking bench for jk_seq_ctrl against an arithmetic reference model.
module tb_jk_seq_ctrl;

    localparam int W  = 4;
    localparam int LW = 8;
    localparam logic [W-1:0] ONE = {{(W - 1){1'b0}}, 1'b1};
    localparam logic [W-1:0] TOP = {1'b1, {(W - 1){1'b0}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [LW-1:0] len;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  q;
    logic [W-1:0]  qb;
    logic          busy;
    logic          done;
    logic          tc;

    int checks = 0;
    int errors = 0;

    // Reference model state: bank value and latched mode.
    logic [W-1:0] m_q;
    logic [1:0]   m_mode;

    always #5 clk = ~clk;

    jk_seq_ctrl #(
        .WIDTH (W),
        .LEN_W (LW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .mode_i     (mode),
        .len_i      (len),
        .load_i     (load),
        .load_val_i (load_val),
        .q_o        (q),
        .qb_o       (qb),
        .busy_o     (busy),
        .done_o     (done),
        .tc_o       (tc)
    );

    // One step of each mode, as plain arithmetic on the bank value.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] v, input logic [1:0] md);
        case (md)
            2'd0:    return v + ONE;
            2'd1:    return v - ONE;
            2'd2:    return {v[W-2:0], ~v[W-1]};
            default: return ~v;
        endcase
    endfunction

    function automatic logic model_tc(input logic [W-1:0] v, input logic [1:0] md);
        case (md)
            2'd0:    return v == {W{1'b1}};
            2'd1:    return v == {W{1'b0}};
            2'd2:    return v == TOP;
            default: return 1'b0;
        endcase
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
    task automatic do_run(input logic [1:0] md, input int n, input bit noise);
        start    = 1'b1;
        mode     = md;
        len      = LW'(n);
        load     = 1'($urandom_range(0, 1));
        load_val = W'($urandom);
        @(posedge clk);
        #1;
        start  = 1'b0;
        load   = 1'b0;
        m_mode = md;
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL run_busy step %0d: busy=%b done=%b, required busy=1 done=0", s, busy,
                         done);
            end
            checks++;
            if (q !== m_q || qb !== ~m_q) begin
                errors++;
                $display("FAIL run_q step %0d mode %0d: q=%b qb=%b, required q=%b qb=%b", s, md, q,
                         qb, m_q, ~m_q);
            end
            checks++;
            if (tc !== model_tc(m_q, md)) begin
                errors++;
                $display("FAIL run_tc step %0d: tc=%b, required %b", s, tc, model_tc(m_q, md));
            end
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                load     = 1'($urandom_range(0, 1));
                load_val = W'($urandom);
                mode     = 2'($urandom);
                len      = LW'($urandom);
            end
            m_q = model_next(m_q, md);
        end
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: busy=%b done=%b, required busy=0 done=1", busy, done);
        end
        checks++;
        if (q !== m_q || tc !== model_tc(m_q, md)) begin
            errors++;
            $display("FAIL done_q: q=%b tc=%b, required q=%b tc=%b", q, tc, m_q,
                     model_tc(m_q, md));
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== m_q) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b q=%b, required 0 0 %b", done, busy, q, m_q);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        load     = 1'b0;
        mode     = 2'b00;
        len      = '0;
        load_val = '0;
        m_q      = '0;
        m_mode   = 2'b00;
        #1;
        checks++;
        if (q !== '0 || qb !== '1) begin
            errors++;
            $display("FAIL reset_q: q=%b qb=%b, required 0000 1111", q, qb);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b tc=%b, required 0 0 0", busy, done, tc);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load(input logic [W-1:0] v);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
        m_q  = v;
        checks++;
        if (q !== v || qb !== ~v) begin
            errors++;
            $display("FAIL load: q=%b qb=%b, required q=%b qb=%b", q, qb, v, ~v);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_flags: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_up_wrap();
        test_load(4'b1110);
        do_run(2'b00, 3, 1'b0);
        checks++;
        if (q !== 4'b0001) begin
            errors++;
            $display("FAIL up_wrap_end: q=%b, required 0001", q);
        end
    endtask

    task automatic test_down();
        test_load(4'b0000);
        do_run(2'b01, 1, 1'b0);
        checks++;
        if (q !== 4'b1111) begin
            errors++;
            $display("FAIL down_wrap_end: q=%b, required 1111", q);
        end
    endtask

    task automatic test_johnson();
        test_load(4'b0000);
        do_run(2'b10, 2 * W, 1'b0);
        checks++;
        if (q !== 4'b0000) begin
            errors++;
            $display("FAIL johnson_period: q=%b, required 0000", q);
        end
    endtask

    task automatic test_len_zero();
        test_load(4'b0110);
        do_run(2'b11, 0, 1'b0);
    endtask

    task automatic test_ignore_during_run();
        test_load(4'b0101);
        do_run(2'b00, 6, 1'b1);
        do_run(2'b11, 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_run(2'b01, 2, 1'b0);
        do_run(2'b10, 3, 1'b0);
        do_run(2'b00, 1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        test_load(4'b0011);
        start = 1'b1;
        mode  = 2'b00;
        len   = LW'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (q !== '0 || qb !== '1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: q=%b qb=%b busy=%b done=%b, required 0000 1111 0 0", q,
                     qb, busy, done);
        end
        @(negedge clk);
        rst    = 1'b0;
        m_q    = '0;
        m_mode = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== '0) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: done=%b busy=%b q=%b, required 0 0 0000",
                         c, done, busy, q);
            end
        end
        do_run(2'b00, 3, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                test_load(W'($urandom));
            end
            do_run(2'($urandom), int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load(4'b1010);
        test_up_wrap();
        test_down();
        test_johnson();
        test_len_zero();
        test_ignore_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
